input_debounce_sync: RTL and testbench
======================================

Name: input_debounce_sync

Overview:
Input conditioner that feeds the team's D flip-flop stages with a clean, clock-domain-safe data bit. An asynchronous external level `din` goes through a multi-stage synchronizer and then a debounce filter. The block outputs a stable level plus single-cycle rise/fall pulses. Downstream registers take `dout` directly as their d input.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal 2..4)
DEBOUNCE_CYCLES, 8, consecutive mismatching cycles required before dout changes (legal 1..2**CNT_W)
CNT_W, 4, debounce counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high; clock clk
en  input  1  filter enable; low freezes the debounce state
din  input  1  raw asynchronous input level
dout  output  1  debounced, synchronized level
rise  output  1  one-cycle pulse when dout goes 0->1
fall  output  1  one-cycle pulse when dout goes 1->0
busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Reset (asynchronous assert, synchronous deassert behaviour is the integrator's job):
  - all synchronizer flops = 0
  - dout = 0, rise = 0, fall = 0, busy = 0
  - counter = 0, state = STABLE
- Synchronizer:
  - SYNC_STAGES flops in series, clocked every edge regardless of en.
  - sync_out = last stage.
  - No logic between stages.
- State machine, two states (all transitions on a clk edge with en = 1):
  - STABLE, with sync_out == dout: counter held at 0, busy = 0.
  - STABLE, with sync_out != dout:
    - If DEBOUNCE_CYCLES == 1: dout <= sync_out, pulse asserted, stay STABLE.
    - Otherwise: go to CHECK with counter <= 1.
  - CHECK, with sync_out == dout (bounce): go to STABLE, counter <= 0, no pulse.
  - CHECK, with sync_out != dout and counter == DEBOUNCE_CYCLES-1:
    - dout <= sync_out
    - rise <= sync_out, fall <= ~sync_out
    - go to STABLE, counter <= 0
  - CHECK, with sync_out != dout otherwise: counter <= counter+1.
  - busy = (state == CHECK), decoded combinationally from the state register.
- Latency: a clean din step held long enough changes dout exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new din. Defaults give 10 edges.
- Pulses:
  - rise and fall are registered and high for exactly one cycle, on the same edge dout changes.
  - They are never both high.
  - They are 0 on every other cycle, including all cycles with en = 0.
- en = 0:
  - state, counter and dout hold their values.
  - Synchronizer keeps sampling.
  - On re-enable, qualification resumes from the held counter.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Mid-qualification reset clears CHECK immediately. dout = 0 even if the old dout was 1, and no fall pulse is generated.
- A din glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches dout.

Test Plan:
1. Reset check: rst = 1 at t = 0, din = 1 -> dout/rise/fall/busy all 0 while rst is high. Release rst with din = 1, en = 1 -> dout = 1 after exactly 10 edges, rise = 1 for one cycle on that edge.
2. Clean 1->0 step: dout = 1 steady, din drops -> busy high from edge 3 to edge 9, dout = 0 and fall = 1 at edge 10, fall = 0 at edge 11.
3. Bounce rejection: din = 0 steady, din pulses high for 4 cycles then low -> busy pulses, dout stays 0, rise never asserts. Repeat with a 7-cycle pulse -> still rejected. An 8-cycle pulse -> rise asserts once.
4. Enable freeze: start a 0->1 qualification, drop en for 5 cycles at counter = 4 -> counter, busy and dout hold, no pulse. Restore en -> dout rises 4 edges later.
5. Reset mid-operation: dout = 1, din falls, assert rst when counter = 3 -> dout = 0 asynchronously, busy = 0, no fall pulse. Release with din = 0 -> no activity.
6. Parameter sweep: DEBOUNCE_CYCLES = 1 and SYNC_STAGES = 3 -> step latency = 4 edges, one pulse per accepted edge.

Source files
------------

// File: rtl/input_debounce_sync.sv
// Input conditioner: multi-flop synchronizer followed by a counting debounce filter.
// Produces a clean level plus registered one-cycle rise/fall pulses.
module input_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [0:0]       ST_STABLE = 1'b0;
  localparam logic [0:0]       ST_CHECK  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchronizer stage: plain flop chain, sampled every edge regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        ST_STABLE: begin
          if (sync_out != dout_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              dout_d = sync_out;
              rise_d = sync_out;
              fall_d = ~sync_out;
            end else begin
              state_d = ST_CHECK;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_CHECK: begin
          if (sync_out == dout_q) begin
            // Bounce back to the current level: abandon the candidate silently
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            dout_d  = sync_out;
            rise_d  = sync_out;
            fall_d  = ~sync_out;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Filter stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_CHECK);

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync: default build plus a 3-stage, 1-cycle build.
module tb_input_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic din = 1'b1;
  logic din2 = 1'b0;
  logic dout, rise, fall, busy;
  logic dout2, rise2, fall2, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .busy(busy)
  );

  input_debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din2),
    .dout(dout2), .rise(rise2), .fall(fall2), .busy(busy2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       din;
    logic [3:0] exp;   // {dout, rise, fall, busy}
  } vec_t;

  vec_t vec[$];

  task automatic push(input logic r, input logic e, input logic d, input logic [3:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.exp = x;
    vec.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s[%0d] got {dout,rise,fall,busy}=%b want=%b", nm, idx, act, want);
    end
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;

    // Reset held with din=1: everything quiet
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1, 4'b0000);
    // Release with din=1: dout rises on edge 10
    for (int e = 1; e <= 11; e++)
      push(1'b0, 1'b1, 1'b1, {e >= 10, e == 10, 1'b0, (e >= 3 && e <= 9)});
    // Clean 1->0 step
    for (int e = 1; e <= 11; e++)
      push(1'b0, 1'b1, 1'b0, {e < 10, 1'b0, e == 10, (e >= 3 && e <= 9)});
    // Short pulses rejected
    for (int e = 1; e <= 12; e++)
      push(1'b0, 1'b1, e <= 4, {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 6)});
    for (int e = 1; e <= 12; e++)
      push(1'b0, 1'b1, e <= 7, {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 9)});
    // 8-cycle pulse accepted, then the return to 0 is accepted as well
    for (int e = 1; e <= 20; e++)
      push(1'b0, 1'b1, e <= 8, {(e >= 10 && e < 18), e == 10, e == 18,
                                ((e >= 3 && e <= 9) || (e >= 11 && e <= 17))});
    for (int e = 1; e <= 2; e++) push(1'b0, 1'b1, 1'b0, 4'b0000);
    // Enable dropped for 5 edges at counter 4
    for (int e = 1; e <= 15; e++)
      push(1'b0, !(e >= 7 && e <= 11), 1'b1, {e >= 15, e == 15, 1'b0, (e >= 3 && e <= 14)});
    for (int e = 1; e <= 2; e++) push(1'b0, 1'b1, 1'b1, 4'b1000);
    // Start a fall qualification up to counter 3
    for (int e = 1; e <= 5; e++) push(1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, e >= 3});

    foreach (vec[i]) begin
      @(negedge clk);
      rst = vec[i].rst; en = vec[i].en; din = vec[i].din;
      @(posedge clk);
      #1;
      chk("vec", i, {dout, rise, fall, busy}, vec[i].exp);
    end

    // Asynchronous reset mid-qualification
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, {dout, rise, fall, busy}, 4'b0000);
    @(posedge clk);
    #1 chk("rst_hold", 0, {dout, rise, fall, busy}, 4'b0000);
    @(negedge clk);
    rst = 1'b0; din = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1 chk("post_rst", e, {dout, rise, fall, busy}, 4'b0000);
    end

    // Second build: 3 sync stages, single-cycle debounce -> latency 4
    rise_cnt = 0;
    fall_cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk) din2 = 1'b1;
      @(posedge clk);
      #1 chk("p_rise", e, {dout2, rise2, fall2, busy2}, {e >= 4, e == 4, 1'b0, 1'b0});
      rise_cnt += int'(rise2); fall_cnt += int'(fall2);
    end
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk) din2 = 1'b0;
      @(posedge clk);
      #1 chk("p_fall", e, {dout2, rise2, fall2, busy2}, {e < 4, 1'b0, e == 4, 1'b0});
      rise_cnt += int'(rise2); fall_cnt += int'(fall2);
    end
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk) din2 = (e == 1);
      @(posedge clk);
      #1 chk("p_glitch", e, {dout2, rise2, fall2, busy2}, {e == 4, e == 4, e == 5, 1'b0});
      rise_cnt += int'(rise2); fall_cnt += int'(fall2);
    end
    chk("p_pulse_count", 0, {2'(rise_cnt), 2'(fall_cnt)}, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
